mmio_dispatch: RTL and testbench

Sequences non-configuration MMIO cycles from the PSL onto a set of internal AFU register targets, one transaction at a time. Decodes the target from the upper address bits and forwards the request. Waits for that target's acknowledge, or for a timeout, then drives the PSL-side acknowledge, read data and parity. Sits between the PSL MMIO port and the AFU register files; configuration-space cycles are handled elsewhere and ignored here.

---
 rtl/mmio_dispatch_pkg.sv | 36 +++
 rtl/mmio_dispatch_parity.sv | 13 +
 rtl/mmio_dispatch.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_dispatch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_dispatch_pkg.sv
// Shared types, constants and the read-word selection helper for the
// PSL MMIO dispatcher.
package mmio_dispatch_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Read data returned when the selected target never acknowledges.
  localparam logic [0:63] TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bit positions inside err_status.
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERLAP = 1;

  // Doubleword reads pass through; word reads replicate the addressed
  // 32-bit half (ad23=1 selects the low-order word [32:63]) into both halves.
  function automatic logic [0:63] word_sel(input logic [0:63] rdata,
                                           input logic        dw,
                                           input logic        ad23);
    logic [0:63] r;
    if (dw) begin
      r = rdata;
    end else if (ad23) begin
      r = {rdata[32:63], rdata[32:63]};
    end else begin
      r = {rdata[0:31], rdata[0:31]};
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_dispatch_parity.sv
// Generic parity generator: XOR reduction of the data word, inverted when
// the odd sense is selected.
module parity #(
  parameter int BITS = 64
) (
  input  logic [0:BITS-1] data_i,
  input  logic            odd_i,
  output logic            par_o
);

  assign par_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/mmio_dispatch.sv
// Sequences non-configuration PSL MMIO cycles onto NUM_TGT internal register
// targets, one transaction at a time, and returns the acknowledge, read data
// and parity to the PSL. Target index comes from the top address bits.
module mmio_dispatch
  import mmio_dispatch_pkg::*;
#(
  parameter int NUM_TGT  = 4,
  parameter int SEL_BITS = $clog2(NUM_TGT),
  parameter int TIMEOUT  = 64
) (
  input  logic                     ha_pclock,
  input  logic                     reset,
  input  logic                     ha_mmval,
  input  logic                     ha_mmcfg,
  input  logic                     ha_mmrnw,
  input  logic                     ha_mmdw,
  input  logic [0:23]              ha_mmad,
  input  logic [0:63]              ha_mmdata,
  input  logic                     odd_parity,
  output logic                     ah_mmack,
  output logic [0:63]              ah_mmdata,
  output logic                     ah_mmdatapar,
  output logic [0:NUM_TGT-1]       tgt_req,
  output logic                     tgt_rnw,
  output logic                     tgt_dw,
  output logic [0:23]              tgt_ad,
  output logic [0:63]              tgt_wdata,
  input  logic [0:NUM_TGT-1]       tgt_ack,
  input  logic [0:64*NUM_TGT-1]    tgt_rdata,
  output logic [0:1]               err_status
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept_s;
  logic               overlap_s;
  logic               timeout_s;
  logic               to_resp_s;
  logic               sel_ack_s;
  logic [SEL_BITS-1:0] in_idx_s;
  logic [SEL_BITS-1:0] sel_idx_s;
  logic [0:63]        sel_rdata_s;
  logic               par_s;

  logic               ack_q, ack_d;
  logic [0:63]        rdata_q, rdata_d;
  logic               par_q;
  logic [0:NUM_TGT-1] req_q, req_d;
  logic               rnw_q, rnw_d;
  logic               dw_q, dw_d;
  logic [0:23]        ad_q, ad_d;
  logic [0:63]        wdata_q, wdata_d;
  logic [0:1]         err_q, err_d;

  // The captured address doubles as the index register for the live
  // transaction, so only the selected target's ack and data are visible.
  assign in_idx_s    = ha_mmad[0:SEL_BITS-1];
  assign sel_idx_s   = ad_q[0:SEL_BITS-1];
  assign sel_ack_s   = tgt_ack[sel_idx_s];
  assign sel_rdata_s = tgt_rdata[{sel_idx_s, 6'd0} +: 64];

  assign accept_s  = ha_mmval && !ha_mmcfg && (state_q == IDLE);
  assign overlap_s = ha_mmval && !ha_mmcfg && (state_q != IDLE);

  // State and timeout counter register.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an ack in the timeout cycle takes priority.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_ack_s) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_ack_s) begin
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d   = RESP;
          timeout_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of every registered output.
  always_comb begin
    to_resp_s = (state_d == RESP) && (state_q != RESP);
    req_d     = '0;
    ack_d     = to_resp_s;

    if (accept_s) begin
      req_d[in_idx_s] = 1'b1;
      ad_d            = ha_mmad;
      wdata_d         = ha_mmdata;
      rnw_d           = ha_mmrnw;
      dw_d            = ha_mmdw;
    end else begin
      ad_d    = ad_q;
      wdata_d = wdata_q;
      rnw_d   = rnw_q;
      dw_d    = dw_q;
    end

    if (!to_resp_s) begin
      rdata_d = rdata_q;
    end else if (!rnw_q) begin
      rdata_d = 64'h0;
    end else if (timeout_s) begin
      rdata_d = TIMEOUT_DATA;
    end else begin
      rdata_d = word_sel(sel_rdata_s, dw_q, ad_q[23]);
    end

    err_d = err_q;
    if (timeout_s) begin
      err_d[ERR_TIMEOUT] = 1'b1;
    end else begin
      err_d[ERR_TIMEOUT] = err_q[ERR_TIMEOUT];
    end
    if (overlap_s) begin
      err_d[ERR_OVERLAP] = 1'b1;
    end else begin
      err_d[ERR_OVERLAP] = err_q[ERR_OVERLAP];
    end
  end

  parity #(.BITS(64)) u_parity (
    .data_i (rdata_d),
    .odd_i  (odd_parity),
    .par_o  (par_s)
  );

  // Output registers; parity is captured in the same edge as the data.
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= 64'h0;
      par_q   <= odd_parity;
      req_q   <= '0;
      rnw_q   <= 1'b0;
      dw_q    <= 1'b0;
      ad_q    <= 24'h0;
      wdata_q <= 64'h0;
      err_q   <= 2'b00;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      par_q   <= par_s;
      req_q   <= req_d;
      rnw_q   <= rnw_d;
      dw_q    <= dw_d;
      ad_q    <= ad_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ah_mmack     = ack_q;
  assign ah_mmdata    = rdata_q;
  assign ah_mmdatapar = par_q;
  assign tgt_req      = req_q;
  assign tgt_rnw      = rnw_q;
  assign tgt_dw       = dw_q;
  assign tgt_ad       = ad_q;
  assign tgt_wdata    = wdata_q;
  assign err_status   = err_q;

endmodule

// File: tb/tb_mmio_dispatch.sv
// Directed bench for mmio_dispatch with NUM_TGT=4, TIMEOUT=8.
module tb_mmio_dispatch;

  logic           ha_pclock;
  logic           reset;
  logic           ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw;
  logic [0:23]    ha_mmad;
  logic [0:63]    ha_mmdata;
  logic           odd_parity;
  logic           ah_mmack;
  logic [0:63]    ah_mmdata;
  logic           ah_mmdatapar;
  logic [0:3]     tgt_req;
  logic           tgt_rnw, tgt_dw;
  logic [0:23]    tgt_ad;
  logic [0:63]    tgt_wdata;
  logic [0:3]     tgt_ack;
  logic [0:255]   tgt_rdata;
  logic [0:1]     err_status;

  int errors = 0;
  int checks = 0;

  mmio_dispatch #(.NUM_TGT(4), .TIMEOUT(8)) dut (
    .ha_pclock    (ha_pclock),
    .reset        (reset),
    .ha_mmval     (ha_mmval),
    .ha_mmcfg     (ha_mmcfg),
    .ha_mmrnw     (ha_mmrnw),
    .ha_mmdw      (ha_mmdw),
    .ha_mmad      (ha_mmad),
    .ha_mmdata    (ha_mmdata),
    .odd_parity   (odd_parity),
    .ah_mmack     (ah_mmack),
    .ah_mmdata    (ah_mmdata),
    .ah_mmdatapar (ah_mmdatapar),
    .tgt_req      (tgt_req),
    .tgt_rnw      (tgt_rnw),
    .tgt_dw       (tgt_dw),
    .tgt_ad       (tgt_ad),
    .tgt_wdata    (tgt_wdata),
    .tgt_ack      (tgt_ack),
    .tgt_rdata    (tgt_rdata),
    .err_status   (err_status)
  );

  initial ha_pclock = 1'b0;
  always #5 ha_pclock = ~ha_pclock;

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge ha_pclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present one MMIO cycle; returns in the REQ cycle.
  task automatic issue(input logic [0:23] ad, input logic rnw, input logic dw,
                       input logic [63:0] wd);
    ha_mmval  = 1'b1;
    ha_mmad   = ad;
    ha_mmrnw  = rnw;
    ha_mmdw   = dw;
    ha_mmdata = wd;
    tick();
    ha_mmval  = 1'b0;
  endtask

  // Full transaction: target acks dly cycles after tgt_req.
  task automatic xact(input string tag, input int tgt, input logic [0:23] ad,
                      input logic rnw, input logic dw, input logic [63:0] wd,
                      input int dly, input logic [63:0] rd,
                      input logic [3:0] exp_req, input logic [63:0] exp_data);
    issue(ad, rnw, dw, wd);
    chk({tag, "_req"}, tgt_req, exp_req);
    chk({tag, "_ad"}, tgt_ad, ad);
    chk({tag, "_wdata"}, tgt_wdata, wd);
    chk({tag, "_rnw"}, tgt_rnw, rnw);
    for (int k = 0; k < dly; k++) begin
      chk({tag, "_early_ack"}, ah_mmack, 1'b0);
      tick();
    end
    tgt_ack[tgt] = 1'b1;
    tgt_rdata[64*tgt +: 64] = rd;
    tick();
    tgt_ack = 4'b0000;
    chk({tag, "_ack"}, ah_mmack, 1'b1);
    chk({tag, "_data"}, ah_mmdata, exp_data);
    chk({tag, "_par"}, ah_mmdatapar, (^exp_data) ^ odd_parity);
    tick();
    chk({tag, "_ack_pulse"}, ah_mmack, 1'b0);
  endtask

  initial begin
    reset = 1'b1; odd_parity = 1'b1;
    ha_mmval = 1'b0; ha_mmcfg = 1'b0; ha_mmrnw = 1'b0; ha_mmdw = 1'b0;
    ha_mmad = 24'h0; ha_mmdata = 64'h0;
    tgt_ack = 4'b0000; tgt_rdata = '0;
    tick(); tick();

    chk("rst_ack", ah_mmack, 1'b0);
    chk("rst_data", ah_mmdata, 64'h0);
    chk("rst_par", ah_mmdatapar, 1'b1);
    chk("rst_req", tgt_req, 4'b0000);
    chk("rst_ad", tgt_ad, 24'h0);
    chk("rst_wdata", tgt_wdata, 64'h0);
    chk("rst_err", err_status, 2'b00);

    reset = 1'b0; odd_parity = 1'b0;
    tick();

    xact("rd_t2_even", 2, 24'h800010, 1'b1, 1'b1, 64'h0, 3,
         64'h0123_4567_89AB_CDEF, 4'b0010, 64'h0123_4567_89AB_CDEF);
    odd_parity = 1'b1;
    xact("rd_t2_odd", 2, 24'h800010, 1'b1, 1'b1, 64'h0, 3,
         64'h0123_4567_89AB_CDEF, 4'b0010, 64'h0123_4567_89AB_CDEF);

    xact("rd32_hi", 1, 24'h400001, 1'b1, 1'b0, 64'h0, 1,
         64'hAAAA_BBBB_CCCC_DDDD, 4'b0100, 64'hCCCC_DDDD_CCCC_DDDD);
    xact("rd32_lo", 3, 24'hC00002, 1'b1, 1'b0, 64'h0, 2,
         64'hAAAA_BBBB_CCCC_DDDD, 4'b0001, 64'hAAAA_BBBB_AAAA_BBBB);

    xact("wr_t0", 0, 24'h000100, 1'b0, 1'b0, 64'h5A5A, 0,
         64'hDEAD_BEEF_0000_0000, 4'b1000, 64'h0);

    xact("ack_at_to", 2, 24'h800000, 1'b1, 1'b1, 64'h0, 8,
         64'h1357_9BDF_2468_ACE0, 4'b0010, 64'h1357_9BDF_2468_ACE0);
    chk("ack_at_to_err", err_status, 2'b00);

    // Second request while the first is in WAIT is dropped.
    issue(24'hC00000, 1'b1, 1'b1, 64'h0);
    chk("ovl_req", tgt_req, 4'b0001);
    tick();
    ha_mmval = 1'b1; ha_mmad = 24'h000000; ha_mmrnw = 1'b0;
    tick();
    ha_mmval = 1'b0;
    chk("ovl_noreq", tgt_req, 4'b0000);
    chk("ovl_err", err_status, 2'b01);
    chk("ovl_ad_kept", tgt_ad, 24'hC00000);
    tgt_ack[3] = 1'b1; tgt_rdata[192 +: 64] = 64'hFEDC_BA98_7654_3210;
    tick();
    tgt_ack = 4'b0000;
    chk("ovl_ack", ah_mmack, 1'b1);
    chk("ovl_data", ah_mmdata, 64'hFEDC_BA98_7654_3210);
    tick();
    chk("ovl_one_ack_a", ah_mmack, 1'b0);
    tick();
    chk("ovl_one_ack_b", ah_mmack, 1'b0);
    chk("ovl_req_idle", tgt_req, 4'b0000);

    // Configuration cycle is ignored.
    ha_mmval = 1'b1; ha_mmcfg = 1'b1; ha_mmad = 24'h400000; ha_mmrnw = 1'b1;
    tick();
    ha_mmval = 1'b0; ha_mmcfg = 1'b0;
    chk("cfg_noreq", tgt_req, 4'b0000);
    tick();
    chk("cfg_noack", ah_mmack, 1'b0);
    chk("cfg_noreq2", tgt_req, 4'b0000);
    chk("cfg_ad_kept", tgt_ad, 24'hC00000);
    chk("cfg_err", err_status, 2'b01);

    // Acknowledge from a non-selected target is ignored.
    issue(24'h400000, 1'b1, 1'b1, 64'h0);
    chk("wt_req", tgt_req, 4'b0100);
    tgt_ack[0] = 1'b1; tgt_rdata[0 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    tgt_ack = 4'b0000;
    chk("wt_noack_a", ah_mmack, 1'b0);
    tick();
    chk("wt_noack_b", ah_mmack, 1'b0);
    tgt_ack[1] = 1'b1; tgt_rdata[64 +: 64] = 64'h0000_0000_0000_0001;
    tick();
    tgt_ack = 4'b0000;
    chk("wt_ack", ah_mmack, 1'b1);
    chk("wt_data", ah_mmdata, 64'h0000_0000_0000_0001);
    chk("wt_par", ah_mmdatapar, 1'b0);
    tick();
    chk("wt_ack_pulse", ah_mmack, 1'b0);

    // No acknowledge: timeout response TIMEOUT+1 cycles after tgt_req.
    issue(24'h800000, 1'b1, 1'b1, 64'h0);
    chk("to_req", tgt_req, 4'b0010);
    chk("to_noack_0", ah_mmack, 1'b0);
    tick();
    chk("to_req_pulse", tgt_req, 4'b0000);
    for (int k = 1; k < 9; k++) begin
      chk("to_noack", ah_mmack, 1'b0);
      tick();
    end
    chk("to_ack", ah_mmack, 1'b1);
    chk("to_data", ah_mmdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to_err", err_status, 2'b11);
    tick();
    chk("to_ack_pulse", ah_mmack, 1'b0);

    // Reset while waiting aborts the transaction.
    issue(24'h800000, 1'b1, 1'b1, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_req", tgt_req, 4'b0000);
    chk("mrst_ack", ah_mmack, 1'b0);
    chk("mrst_err", err_status, 2'b00);
    chk("mrst_data", ah_mmdata, 64'h0);
    tgt_ack[2] = 1'b1; tgt_rdata[128 +: 64] = 64'h1111_2222_3333_4444;
    tick();
    tgt_ack = 4'b0000;
    chk("mrst_late_ack_a", ah_mmack, 1'b0);
    tick();
    chk("mrst_late_ack_b", ah_mmack, 1'b0);
    xact("post_rst", 2, 24'h800008, 1'b1, 1'b1, 64'h0, 1,
         64'h0F0F_0F0F_0F0F_0F0E, 4'b0010, 64'h0F0F_0F0F_0F0F_0F0E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
